// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO register pair and multi-cycle MULT/MULTU/DIV/DIVU sequencer with pipeline stall.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle combinational multiply, divide stays iterative.
module hilo_muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        flush_i,
  input  logic [5:0]  alu_control_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  localparam logic [5:0] ALU_MTHI  = 6'h11;
  localparam logic [5:0] ALU_MTLO  = 6'h13;
  localparam logic [5:0] ALU_MULT  = 6'h18;
  localparam logic [5:0] ALU_MULTU = 6'h19;
  localparam logic [5:0] ALU_DIV   = 6'h1A;
  localparam logic [5:0] ALU_DIVU  = 6'h1B;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  state_t state, state_nxt;

  logic        is_mul, is_div, is_sgn, accept, fast_mul, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [31:0] acc_hi, acc_lo, opd;
  logic [4:0]  cnt;
  logic        neg_res, neg_rem, div_zero;

  assign is_mul = (alu_control_i == ALU_MULT) || (alu_control_i == ALU_MULTU);
  assign is_div = (alu_control_i == ALU_DIV)  || (alu_control_i == ALU_DIVU);
  assign is_sgn = (alu_control_i == ALU_MULT) || (alu_control_i == ALU_DIV);
  assign accept = (state == S_IDLE) && start_i && (is_mul || is_div) && !flush_i;
  assign a_neg  = is_sgn && a_i[31];
  assign b_neg  = is_sgn && b_i[31];
  // 0x80000000 negates to itself, which read unsigned is exactly 2^31
  assign a_mag  = a_neg ? (~a_i + 32'd1) : a_i;
  assign b_mag  = b_neg ? (~b_i + 32'd1) : b_i;

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] ext_a, ext_b, fast_prod;
  assign fast_mul  = accept && is_mul;
  assign ext_a     = {{32{a_neg}}, a_i};
  assign ext_b     = {{32{b_neg}}, b_i};
  assign fast_prod = ext_a * ext_b;
`else
  assign fast_mul  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    done_o    = 1'b0;
    case (state)
      S_IDLE: if (accept) begin
        stall_o   = !fast_mul;
        state_nxt = fast_mul ? S_DONE : (is_mul ? S_MUL : S_DIV);
      end
      S_MUL, S_DIV: begin
        stall_o = 1'b1;
        if (cnt == 5'd31) state_nxt = S_DONE;
      end
      S_DONE: begin
        done_o    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (flush_i) state_nxt = S_IDLE;
  end

  // One radix-2 step: shift-add multiply or restoring divide on {acc_hi, acc_lo}
  logic [32:0] sum, trial;
  logic        ge;
  logic [31:0] sub, step_hi, step_lo;
  logic [63:0] prod, prod_fix;
  logic [31:0] res_hi, res_lo;

  always_comb begin
    sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : 33'd0);
    trial = {acc_hi, acc_lo[31]};
    ge    = trial >= {1'b0, opd};
    sub   = trial[31:0] - opd;
    if (state == S_MUL) begin
      step_hi = sum[32:1];
      step_lo = {sum[0], acc_lo[31:1]};
    end else begin
      step_hi = ge ? sub : trial[31:0];
      step_lo = {acc_lo[30:0], ge};
    end
    prod     = {step_hi, step_lo};
    prod_fix = neg_res ? (~prod + 64'd1) : prod;
    if (state == S_MUL) begin
      res_hi = prod_fix[63:32];
      res_lo = prod_fix[31:0];
    end else begin
      // divide by zero: all-ones quotient, remainder reassembles the dividend
      res_hi = neg_rem ? (~step_hi + 32'd1) : step_hi;
      res_lo = div_zero ? 32'hFFFF_FFFF : (neg_res ? (~step_lo + 32'd1) : step_lo);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_o     <= '0;
      lo_o     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opd      <= '0;
      cnt      <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else if (accept) begin
      acc_hi   <= '0;
      acc_lo   <= is_mul ? b_mag : a_mag;
      opd      <= is_mul ? a_mag : b_mag;
      cnt      <= '0;
      neg_res  <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
      div_zero <= (b_i == 32'd0);
`ifdef MULDIV_FAST_MUL_EN
      if (fast_mul) begin
        hi_o <= fast_prod[63:32];
        lo_o <= fast_prod[31:0];
      end
`endif
    end else if (state == S_IDLE && start_i && !flush_i) begin
      if (alu_control_i == ALU_MTHI) hi_o <= a_i;
      if (alu_control_i == ALU_MTLO) lo_o <= a_i;
    end else if ((state == S_MUL || state == S_DIV) && !flush_i) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      cnt    <= cnt + 5'd1;
      if (cnt == 5'd31) begin
        hi_o <= res_hi;
        lo_o <= res_lo;
      end
    end
  end
endmodule
